// File: rtl/approx_add_pipe_if.sv
`timescale 1ns/1ps
// approx_add_pipe_if: operand/result handshake and statistics bundle for approx_add_pipe
interface approx_add_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int STAT_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH:0]    o;
    logic [WIDTH:0]    o_err;
    logic              stat_clr;
    logic [STAT_W-1:0] err_sum;
    logic [STAT_W-1:0] err_cnt;
    logic [WIDTH:0]    err_max;

    modport master (
        output in_valid, a, b, mode, out_ready, stat_clr,
        input  in_ready, out_valid, o, o_err, err_sum, err_cnt, err_max
    );
    modport slave (
        input  in_valid, a, b, mode, out_ready, stat_clr,
        output in_ready, out_valid, o, o_err, err_sum, err_cnt, err_max
    );
endinterface

// File: rtl/approx_add_pipe.sv
`timescale 1ns/1ps
// approx_add_pipe: pipelined lower-part-OR approximate adder with ready/valid and error statistics
module approx_add_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int STAGES      = 2,
    parameter int STAT_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    approx_add_pipe_if.slave bus
);
    localparam int KC = (APPROX_BITS == 0) ? 0 : APPROX_BITS - 1;
    localparam int SW = ((STAT_W > WIDTH + 1) ? STAT_W : WIDTH + 1) + 1;
    localparam logic [WIDTH:0] LO_MASK = ~({(WIDTH + 1){1'b1}} << APPROX_BITS);
    localparam logic [SW-1:0] SUM_MAX = {{(SW - STAT_W){1'b0}}, {STAT_W{1'b1}}};

    logic [WIDTH:0]    w_exact, w_hi, w_apx, w_o, w_err;
    logic [WIDTH+1:0]  w_diff;
    logic              w_c;
    logic [STAGES-1:0] w_take;
    logic [SW-1:0]     w_sum;
    logic              w_xfer;

    logic [STAGES-1:0] r_v;
    logic [WIDTH:0]    r_o [STAGES];
    logic [WIDTH:0]    r_e [STAGES];
    logic [STAT_W-1:0] r_sum, r_cnt;
    logic [WIDTH:0]    r_max;

    always_comb begin
        w_exact = {1'b0, bus.a} + {1'b0, bus.b};
        w_c     = (APPROX_BITS != 0) && bus.a[KC] && bus.b[KC];
        w_hi    = ({1'b0, bus.a} >> APPROX_BITS) + ({1'b0, bus.b} >> APPROX_BITS) + (WIDTH + 1)'(w_c);
        w_apx   = (w_hi << APPROX_BITS) | ({1'b0, bus.a | bus.b} & LO_MASK);
        w_o     = bus.mode ? w_apx : w_exact;
        w_diff  = {1'b0, w_exact} - {1'b0, w_o};
        w_err   = w_diff[WIDTH+1] ? (WIDTH + 1)'(-w_diff) : w_diff[WIDTH:0];
    end

    // A stage can load when it or any stage downstream of it is empty, or the sink is ready.
    always_comb begin
        logic t;
        t      = bus.out_ready;
        w_take = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            t         = t || !r_v[i];
            w_take[i] = t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_o[i] <= '0;
                r_e[i] <= '0;
            end
        end else begin
            if (w_take[0]) begin
                r_v[0] <= bus.in_valid;
                r_o[0] <= w_o;
                r_e[0] <= w_err;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_take[i]) begin
                    r_v[i] <= r_v[i-1];
                    r_o[i] <= r_o[i-1];
                    r_e[i] <= r_e[i-1];
                end
            end
        end
    end

    assign w_xfer = r_v[STAGES-1] && bus.out_ready;
    assign w_sum  = SW'(r_sum) + SW'(r_e[STAGES-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_max <= '0;
        end else if (bus.stat_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_max <= '0;
        end else if (w_xfer) begin
            r_sum <= (w_sum > SUM_MAX) ? '1 : w_sum[STAT_W-1:0];
            if (r_e[STAGES-1] != '0 && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (r_e[STAGES-1] > r_max) r_max <= r_e[STAGES-1];
        end
    end

    assign bus.in_ready  = w_take[0];
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.o         = r_o[STAGES-1];
    assign bus.o_err     = r_e[STAGES-1];
    assign bus.err_sum   = r_sum;
    assign bus.err_cnt   = r_cnt;
    assign bus.err_max   = r_max;
endmodule

// File: tb/tb_approx_add_pipe.sv
`timescale 1ns/1ps
// tb_approx_add_pipe: directed checks plus random scoreboard over every approximate-part size
module tb_approx_add_pipe;
    localparam int N = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rand_go = 1'b0;
    int   rand_done = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    approx_add_pipe_if #(.WIDTH(8), .STAT_W(24)) bus ();
    approx_add_pipe_if #(.WIDTH(8), .STAT_W(4))  sbus ();

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .STAT_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));
    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .STAT_W(4)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: low K bits are a plain OR, the top adds with the carry guessed from bit K-1.
    function automatic int ref_o(input int a, input int b, input int m, input int k);
        int p;
        if (m == 0 || k == 0) return a + b;
        p = 2 ** k;
        return (a / p + b / p + ((a / (p / 2)) % 2) * ((b / (p / 2)) % 2)) * p + ((a | b) % p);
    endfunction

    for (genvar k = 0; k <= 8; k++) begin : g_rnd
        approx_add_pipe_if #(.WIDTH(8), .STAT_W(24)) rb ();
        approx_add_pipe #(.WIDTH(8), .APPROX_BITS(k), .STAGES(k % 4 + 1), .STAT_W(24)) u (.clk(clk), .rst(rst), .bus(rb));

        initial begin
            int q_o[$];
            int q_e[$];
            int sent, got, sum, cnt, mx, eo, ee;
            sent = 0; got = 0; sum = 0; cnt = 0; mx = 0;
            rb.in_valid = 1'b0; rb.out_ready = 1'b0; rb.stat_clr = 1'b0;
            rb.mode = 1'b0; rb.a = '0; rb.b = '0;
            wait (rand_go);
            for (int c = 0; c < 20 * N && got < N; c++) begin
                @(negedge clk);
                rb.in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
                rb.a         = 8'($urandom);
                rb.b         = 8'($urandom);
                rb.mode      = 1'($urandom);
                rb.out_ready = $urandom_range(0, 3) != 0;
                #1;
                if (rb.out_valid && rb.out_ready) begin
                    chk($sformatf("k%0d_nonempty", k), 32'(q_o.size() != 0), 1);
                    if (q_o.size() != 0) begin
                        eo = q_o.pop_front();
                        ee = q_e.pop_front();
                        chk($sformatf("k%0d_o", k), 32'(rb.o), eo);
                        chk($sformatf("k%0d_err", k), 32'(rb.o_err), ee);
                        sum += ee;
                        if (ee != 0) cnt++;
                        if (ee > mx) mx = ee;
                    end
                    got++;
                end
                if (rb.in_valid && rb.in_ready) begin
                    eo = ref_o(int'(rb.a), int'(rb.b), int'(rb.mode), k);
                    ee = int'(rb.a) + int'(rb.b) - eo;
                    if (ee < 0) ee = -ee;
                    q_o.push_back(eo);
                    q_e.push_back(ee);
                    sent++;
                end
            end
            @(negedge clk);
            rb.in_valid = 1'b0;
            rb.out_ready = 1'b0;
            #1;
            chk($sformatf("k%0d_beats", k), got, N);
            chk($sformatf("k%0d_sum", k), 32'(rb.err_sum), sum);
            chk($sformatf("k%0d_cnt", k), 32'(rb.err_cnt), cnt);
            chk($sformatf("k%0d_max", k), 32'(rb.err_max), mx);
            rand_done++;
        end
    end

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic m, input int eo, input int ee);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.mode = m; bus.out_ready = 1'b1;
        #1 chk("beat_rdy", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("beat_lat", 32'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        chk("beat_ov", 32'(bus.out_valid), 1);
        chk("beat_o", 32'(bus.o), eo);
        chk("beat_err", 32'(bus.o_err), ee);
        @(negedge clk);
    endtask

    task automatic stats(input string tag, input int s, input int c, input int m);
        #1;
        chk({tag, "_sum"}, 32'(bus.err_sum), s);
        chk({tag, "_cnt"}, 32'(bus.err_cnt), c);
        chk({tag, "_max"}, 32'(bus.err_max), m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, first, last, nov;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.mode = 1'b0; bus.out_ready = 1'b0; bus.stat_clr = 1'b0;
        sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.mode = 1'b0; sbus.out_ready = 1'b0; sbus.stat_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_rdy", 32'(bus.in_ready), 1);
        chk("rst_o", 32'(bus.o), 0);
        stats("rst", 0, 0, 0);

        beat(8'd200, 8'd100, 1'b0, 'h12C, 0);
        stats("exact", 0, 0, 0);
        beat(8'h0F, 8'h01, 1'b1, 'h00F, 1);
        stats("carry", 1, 1, 1);

        @(negedge clk); bus.stat_clr = 1'b1;
        @(negedge clk); bus.stat_clr = 1'b0;
        stats("clr", 0, 0, 0);
        beat(8'h08, 8'h08, 1'b1, 'h018, 8);
        beat(8'hFF, 8'hFF, 1'b1, 'h1FF, 1);
        stats("corner", 9, 2, 8);

        bus.out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.mode = 1'b0; bus.a = 8'(10 * (acc + 1)); bus.b = 8'(acc + 1);
            #1 if (bus.in_ready) acc++;
        end
        chk("bp_accepted", acc, 2);
        chk("bp_rdy", 32'(bus.in_ready), 0);
        chk("bp_o_hold", 32'(bus.o), 11);
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid = acc < 4;
            bus.a = 8'(10 * (acc + 1)); bus.b = 8'(acc + 1);
            #1;
            if (bus.out_valid) begin
                chk("bp_order", 32'(bus.o), 11 * (got + 1));
                if (got == 0) first = c;
                last = c;
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        bus.in_valid = 1'b0;
        chk("bp_drained", got, 4);
        chk("bp_rate", last - first, 3);
        @(negedge clk);
        stats("bp", 9, 2, 8);

        @(negedge clk);
        sbus.out_ready = 1'b1; sbus.in_valid = 1'b1; sbus.mode = 1'b1; sbus.a = 8'h0F; sbus.b = 8'h01;
        repeat (20) @(negedge clk);
        sbus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("sat_sum", 32'(sbus.err_sum), 15);
        chk("sat_cnt", 32'(sbus.err_cnt), 15);
        chk("sat_max", 32'(sbus.err_max), 1);
        @(negedge clk); sbus.in_valid = 1'b1;
        @(negedge clk); sbus.in_valid = 1'b0;
        @(negedge clk);
        #1 chk("clrx_ov", 32'(sbus.out_valid), 1);
        sbus.stat_clr = 1'b1;
        @(negedge clk);
        sbus.stat_clr = 1'b0;
        #1;
        chk("clrx_sum", 32'(sbus.err_sum), 0);
        chk("clrx_cnt", 32'(sbus.err_cnt), 0);
        chk("clrx_max", 32'(sbus.err_max), 0);
        chk("clrx_ov0", 32'(sbus.out_valid), 0);

        rand_go = 1'b1;
        wait (rand_done == 9);
        rand_go = 1'b0;

        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.mode = 1'b1; bus.a = 8'h0F; bus.b = 8'h01;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("mid_ov", 32'(bus.out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(bus.out_valid), 0);
        chk("mid_rst_o", 32'(bus.o), 0);
        chk("mid_rst_err", 32'(bus.o_err), 0);
        stats("mid_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rdy", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1; nov = 0;
        repeat (5) begin
            @(negedge clk);
            #1 if (bus.out_valid) nov++;
        end
        chk("mid_stale", nov, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
